// File: rtl/sky_xu_pkg.sv
// Shared XU decode definitions: opcodes, instruction field positions and the
// decoded control payload.
package sky_xu_pkg;

   localparam int unsigned REG_AW  = 4;
   localparam int unsigned ALU_W   = 4;
   localparam int unsigned OPC_W   = 4;
   localparam int unsigned IMM_W   = 12;
   localparam int unsigned INSTR_W = 32;

   localparam int unsigned OPC_LO = 28;
   localparam int unsigned RS1_LO = 24;
   localparam int unsigned RS2_LO = 20;
   localparam int unsigned RD_LO  = 16;
   localparam int unsigned FN_LO  = 12;
   localparam int unsigned IMM_LO = 0;

   localparam logic [OPC_W-1:0] OP_RTYPE  = 4'd0;
   localparam logic [OPC_W-1:0] OP_ITYPE  = 4'd1;
   localparam logic [OPC_W-1:0] OP_LOAD   = 4'd2;
   localparam logic [OPC_W-1:0] OP_STORE  = 4'd3;
   localparam logic [OPC_W-1:0] OP_BRANCH = 4'd4;

   typedef struct packed {
      logic [ALU_W-1:0] alu_op;
      logic             mem_read;
      logic             mem_write;
      logic             reg_write;
      logic             is_branch;
      logic             illegal;
      logic             use_imm;
      logic             uses_rs2;
   } decode_ctrl_t;

   // Opcode to control mapping; unknown opcodes raise only illegal.
   function automatic decode_ctrl_t decode_op(input logic [OPC_W-1:0] opc,
                                              input logic [ALU_W-1:0] funct);
      decode_ctrl_t c;
      c = '0;
      case (opc)
         OP_RTYPE:  begin c.alu_op = funct; c.reg_write = 1'b1; c.uses_rs2 = 1'b1; end
         OP_ITYPE:  begin c.alu_op = funct; c.reg_write = 1'b1; c.use_imm = 1'b1; end
         OP_LOAD:   begin c.mem_read = 1'b1; c.reg_write = 1'b1; c.use_imm = 1'b1; end
         OP_STORE:  begin c.mem_write = 1'b1; c.use_imm = 1'b1; c.uses_rs2 = 1'b1; end
         OP_BRANCH: begin c.alu_op = funct; c.is_branch = 1'b1; c.uses_rs2 = 1'b1; end
         default:   c.illegal = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/sky_decode_fwd_mux.sv
// Priority operand forward select for one source register: EX > MEM > WB > RF.
module sky_decode_fwd_mux
   import sky_xu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [REG_AW-1:0] src_i,
   input  logic [XLEN-1:0]   rf_data_i,
   input  logic              ex_fwd_i,
   input  logic [REG_AW-1:0] ex_rd_i,
   input  logic [XLEN-1:0]   ex_data_i,
   input  logic              mem_we_i,
   input  logic [REG_AW-1:0] mem_rd_i,
   input  logic [XLEN-1:0]   mem_data_i,
   input  logic              wb_we_i,
   input  logic [REG_AW-1:0] wb_rd_i,
   input  logic [XLEN-1:0]   wb_data_i,
   output logic [XLEN-1:0]   data_o
);

   // r0 is hardwired in the register file and never takes a forward.
   always_comb begin
      data_o = rf_data_i;
      if (src_i != '0) begin
         if (ex_fwd_i && (ex_rd_i == src_i))        data_o = ex_data_i;
         else if (mem_we_i && (mem_rd_i == src_i))  data_o = mem_data_i;
         else if (wb_we_i && (wb_rd_i == src_i))    data_o = wb_data_i;
      end
   end

endmodule

// File: rtl/sky_decode_stage_hs.sv
// Handshaked XU decode stage: decode, register read with forwarding,
// load-use bubble insertion, flush and a saturating hazard stall counter.
module sky_decode_stage_hs
   import sky_xu_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [XLEN-1:0]    pc_in,
   input  logic [INSTR_W-1:0] instruction,
   output logic [REG_AW-1:0]  rf_read_addr1,
   output logic [REG_AW-1:0]  rf_read_addr2,
   input  logic [XLEN-1:0]    rf_read_data1,
   input  logic [XLEN-1:0]    rf_read_data2,
   input  logic               ex_reg_write,
   input  logic               ex_mem_read,
   input  logic [REG_AW-1:0]  ex_rd_addr,
   input  logic [XLEN-1:0]    ex_result,
   input  logic               mem_reg_write,
   input  logic [REG_AW-1:0]  mem_rd_addr,
   input  logic [XLEN-1:0]    mem_result,
   input  logic               wb_reg_write,
   input  logic [REG_AW-1:0]  wb_write_addr,
   input  logic [XLEN-1:0]    wb_write_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    pc_out,
   output logic [XLEN-1:0]    operand_a,
   output logic [XLEN-1:0]    operand_b,
   output logic [XLEN-1:0]    store_data,
   output logic [XLEN-1:0]    branch_offset,
   output logic [REG_AW-1:0]  rd_addr,
   output logic [ALU_W-1:0]   alu_op,
   output logic               mem_read,
   output logic               mem_write,
   output logic               reg_write,
   output logic               is_branch,
   output logic               illegal,
   output logic [CNT_W-1:0]   stall_count
);

   logic [OPC_W-1:0]  opc;
   logic [REG_AW-1:0] rs1, rs2, rd;
   logic [ALU_W-1:0]  funct;
   logic [IMM_W-1:0]  imm;
   logic [XLEN-1:0]   imm_sext;
   decode_ctrl_t      dec;
   logic [XLEN-1:0]   fwd_a, fwd_b, fwd_sd;
   logic              ex_fwd, hazard, advance, accept;

   assign opc      = instruction[OPC_LO +: OPC_W];
   assign rs1      = instruction[RS1_LO +: REG_AW];
   assign rs2      = instruction[RS2_LO +: REG_AW];
   assign rd       = instruction[RD_LO  +: REG_AW];
   assign funct    = instruction[FN_LO  +: ALU_W];
   assign imm      = instruction[IMM_LO +: IMM_W];
   assign imm_sext = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
   assign dec      = decode_op(opc, funct);

   assign rf_read_addr1 = rs1;
   assign rf_read_addr2 = rs2;

   // A load in EX has no data yet: it is a hazard, never a forward source.
   assign ex_fwd  = ex_reg_write && !ex_mem_read;
   assign hazard  = in_valid && ex_mem_read && (ex_rd_addr != '0) &&
                    ((ex_rd_addr == rs1) || (dec.uses_rs2 && (ex_rd_addr == rs2)));
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance && !hazard && !flush;
   assign accept   = in_valid && !hazard;

   sky_decode_fwd_mux #(.XLEN(XLEN)) u_fwd_a (
      .src_i(rs1), .rf_data_i(rf_read_data1),
      .ex_fwd_i(ex_fwd), .ex_rd_i(ex_rd_addr), .ex_data_i(ex_result),
      .mem_we_i(mem_reg_write), .mem_rd_i(mem_rd_addr), .mem_data_i(mem_result),
      .wb_we_i(wb_reg_write), .wb_rd_i(wb_write_addr), .wb_data_i(wb_write_data),
      .data_o(fwd_a));

   sky_decode_fwd_mux #(.XLEN(XLEN)) u_fwd_b (
      .src_i(rs2), .rf_data_i(rf_read_data2),
      .ex_fwd_i(ex_fwd), .ex_rd_i(ex_rd_addr), .ex_data_i(ex_result),
      .mem_we_i(mem_reg_write), .mem_rd_i(mem_rd_addr), .mem_data_i(mem_result),
      .wb_we_i(wb_reg_write), .wb_rd_i(wb_write_addr), .wb_data_i(wb_write_data),
      .data_o(fwd_b));

   sky_decode_fwd_mux #(.XLEN(XLEN)) u_fwd_sd (
      .src_i(rs2), .rf_data_i(rf_read_data2),
      .ex_fwd_i(ex_fwd), .ex_rd_i(ex_rd_addr), .ex_data_i(ex_result),
      .mem_we_i(mem_reg_write), .mem_rd_i(mem_rd_addr), .mem_data_i(mem_result),
      .wb_we_i(wb_reg_write), .wb_rd_i(wb_write_addr), .wb_data_i(wb_write_data),
      .data_o(fwd_sd));

   logic              valid_d, valid_q;
   logic [XLEN-1:0]   pc_d, pc_q, opa_d, opa_q, opb_d, opb_q, sd_d, sd_q, boff_d, boff_q;
   logic [REG_AW-1:0] rd_d, rd_q;
   logic [ALU_W-1:0]  alu_d, alu_q;
   logic              mrd_d, mrd_q, mwr_d, mwr_q, rwr_d, rwr_q, br_d, br_q, ill_d, ill_q;
   logic [CNT_W-1:0]  stall_d, stall_q;

   // Next state: flush wins, then advance captures or bubbles, else hold.
   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      sd_d    = sd_q;
      boff_d  = boff_q;
      rd_d    = rd_q;
      alu_d   = alu_q;
      mrd_d   = mrd_q;
      mwr_d   = mwr_q;
      rwr_d   = rwr_q;
      br_d    = br_q;
      ill_d   = ill_q;
      stall_d = (hazard && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (advance) begin
         valid_d = accept;
         if (accept) begin
            pc_d   = pc_in;
            opa_d  = fwd_a;
            opb_d  = dec.use_imm ? imm_sext : fwd_b;
            sd_d   = fwd_sd;
            boff_d = imm_sext;
            rd_d   = rd;
            alu_d  = dec.alu_op;
            mrd_d  = dec.mem_read;
            mwr_d  = dec.mem_write;
            rwr_d  = dec.reg_write;
            br_d   = dec.is_branch;
            ill_d  = dec.illegal;
         end else begin
            mrd_d = 1'b0;
            mwr_d = 1'b0;
            rwr_d = 1'b0;
            br_d  = 1'b0;
            ill_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         sd_q    <= '0;
         boff_q  <= '0;
         rd_q    <= '0;
         alu_q   <= '0;
         mrd_q   <= 1'b0;
         mwr_q   <= 1'b0;
         rwr_q   <= 1'b0;
         br_q    <= 1'b0;
         ill_q   <= 1'b0;
         stall_q <= '0;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         sd_q    <= sd_d;
         boff_q  <= boff_d;
         rd_q    <= rd_d;
         alu_q   <= alu_d;
         mrd_q   <= mrd_d;
         mwr_q   <= mwr_d;
         rwr_q   <= rwr_d;
         br_q    <= br_d;
         ill_q   <= ill_d;
         stall_q <= stall_d;
      end
   end

   assign out_valid     = valid_q;
   assign pc_out        = pc_q;
   assign operand_a     = opa_q;
   assign operand_b     = opb_q;
   assign store_data    = sd_q;
   assign branch_offset = boff_q;
   assign rd_addr       = rd_q;
   assign alu_op        = alu_q;
   assign mem_read      = mrd_q;
   assign mem_write     = mwr_q;
   assign reg_write     = rwr_q;
   assign is_branch     = br_q;
   assign illegal       = ill_q;
   assign stall_count   = stall_q;

endmodule
